// File: rtl/seq_detector_1011.sv
// -----------------------------------------------------------------------------
// seq_detector_1011
//
// Serial detector for the bit pattern 1-0-1-1 (first bit oldest) on the
// single-bit stream coming out of the 2:1 mux stage. Overlapping matches are
// recognised, so 1011011 yields two detections. Each detection produces a
// one-cycle registered pulse on `match`.
//
// Optional feature (macro SEQDET_COUNT_EN):
//   defined   - a COUNT_W-bit saturating counter tallies `match` pulses and
//               `clr` clears it synchronously (clr beats a coincident
//               increment).
//   undefined - no counter register; `count` is constant 0 and `clr` is
//               ignored. The FSM and `match` behave identically.
//
// Handshake: there is no backpressure. `din` is consumed on every rising edge
// where `din_valid` is 1 and ignored (including X) on every other edge.
//
// Parameters:
//   COUNT_W   width of the match counter, 1..16 (default 8)
//
// Ports:
//   clk        in   system clock, rising-edge
//   rst        in   synchronous, active-high reset (overrides valid and clr)
//   din        in   serial data bit
//   din_valid  in   qualifies `din` on this edge
//   clr        in   synchronous clear of `count`; FSM and `match` untouched
//   match      out  one-cycle pulse per detected 1011
//   state      out  current FSM state code, for debug
//   count      out  saturating match count (0 when the counter is absent)
// -----------------------------------------------------------------------------
module seq_detector_1011 #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               clr,
  output logic               match,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] count
);

  // Each code is the length of the pattern prefix seen so far.
  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   match_q, match_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    case (state_q)
      S0: begin
        if (din_valid) state_d = din ? S1 : S0;
      end
      S1: begin
        if (din_valid) state_d = din ? S1 : S10;
      end
      S10: begin
        if (din_valid) state_d = din ? S101 : S0;
      end
      S101: begin
        // The only way into S1011 is this edge, so the pulse is raised here
        // once; a stall while sitting in S1011 cannot re-trigger it.
        if (din_valid) begin
          state_d = din ? S1011 : S10;
          match_d = din;
        end
      end
      S1011: begin
        // The trailing "1" doubles as the start of a new pattern.
        if (din_valid) state_d = din ? S1 : S10;
      end
      default: begin
        // Codes 5..7 recover unconditionally.
        state_d = S0;
      end
    endcase
  end

  assign match = match_q;
  assign state = state_q;

`ifdef SEQDET_COUNT_EN
  logic [COUNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // The increment follows the visible `match` pulse, so count lags match by
  // one edge.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (match_q && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  assign count = count_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign count      = '0;
`endif

endmodule
